// File: rtl/mac_pkg.sv
// Shared widths, types and the saturation helper for the 5-tap dot-product unit.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 16;
    localparam int TAPS   = 5;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [OUT_W-1:0]  out_t;

    localparam sum_t SAT_MAX = sum_t'((1 << OUT_W) - 1);

    // Returns {overflow, clamped result}.
    function automatic logic [OUT_W:0] sat_out(input sum_t sum);
        logic [OUT_W:0] res;
        if (sum > SAT_MAX) begin
            res = {1'b1, {OUT_W{1'b1}}};
        end else begin
            res = {1'b0, sum[OUT_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_sat_stage.sv
// Final pipeline stage: three-way add, saturate, and hold the result until the next valid set.
module mac_sat_stage
    import mac_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_valid,
    input  sum_t  i_sa,
    input  sum_t  i_sb,
    input  prod_t i_p5,
    output out_t  o_out,
    output logic  o_valid,
    output logic  o_ovf
);

    sum_t           w_total;
    logic [OUT_W:0] w_sat;
    out_t           r_out;
    logic           r_valid;
    logic           r_ovf;

    assign w_total = i_sa + i_sb + sum_t'(i_p5);
    assign w_sat   = sat_out(w_total);

    // Result registers only move on valid stages so idle cycles leave the last answer visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_out <= w_sat[OUT_W-1:0];
                r_ovf <= w_sat[OUT_W];
            end
        end
    end

    assign o_out   = r_out;
    assign o_valid = r_valid;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/mac5_dot.sv
// Three-stage pipelined unsigned 5-tap dot product with a saturated 16-bit result.
module mac5_dot
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] A2,
    input  logic [DATA_W-1:0] A3,
    input  logic [DATA_W-1:0] A4,
    input  logic [DATA_W-1:0] A5,
    input  logic [DATA_W-1:0] c1,
    input  logic [DATA_W-1:0] c2,
    input  logic [DATA_W-1:0] c3,
    input  logic [DATA_W-1:0] c4,
    input  logic [DATA_W-1:0] c5,
    input  logic              in_valid,
    output logic [OUT_W-1:0]  Output,
    output logic              out_valid,
    output logic              overflow
);

    data_t w_a [TAPS];
    data_t w_c [TAPS];
    prod_t r_p [TAPS];
    logic  r_v1;
    sum_t  r_sa;
    sum_t  r_sb;
    prod_t r_p5;
    logic  r_v2;

    assign w_a[0] = A1;
    assign w_a[1] = A2;
    assign w_a[2] = A3;
    assign w_a[3] = A4;
    assign w_a[4] = A5;
    assign w_c[0] = c1;
    assign w_c[1] = c2;
    assign w_c[2] = c3;
    assign w_c[3] = c4;
    assign w_c[4] = c5;

    // Datapath registers load every cycle; only the valid bits decide what reaches the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_p[i] <= '0;
            end
            r_v1 <= 1'b0;
            r_sa <= '0;
            r_sb <= '0;
            r_p5 <= '0;
            r_v2 <= 1'b0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                r_p[i] <= prod_t'(w_a[i]) * prod_t'(w_c[i]);
            end
            r_v1 <= in_valid;
            r_sa <= sum_t'(r_p[0]) + sum_t'(r_p[1]);
            r_sb <= sum_t'(r_p[2]) + sum_t'(r_p[3]);
            r_p5 <= r_p[4];
            r_v2 <= r_v1;
        end
    end

    mac_sat_stage u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_v2),
        .i_sa    (r_sa),
        .i_sb    (r_sb),
        .i_p5    (r_p5),
        .o_out   (Output),
        .o_valid (out_valid),
        .o_ovf   (overflow)
    );

endmodule

// File: tb/tb_mac5_dot.sv
// Self-checking bench for mac5_dot: vector table plus scoreboard queue checked on every falling edge.
module tb_mac5_dot;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  A1, A2, A3, A4, A5;
    logic [7:0]  c1, c2, c3, c4, c5;
    logic        in_valid = 1'b0;
    logic [15:0] Output;
    logic        out_valid;
    logic        overflow;

    typedef struct {
        logic [4:0][7:0] a;
        logic [4:0][7:0] c;
        int              expOut;
        bit              expOvf;
    } vec_t;

    typedef struct {
        int out;
        bit ovf;
        int cyc;
    } exp_t;

    vec_t vecs [8];
    exp_t q [$];

    int cycle = 0;
    int total = 0;
    int passed = 0;
    bit started = 1'b0;
    bit rstAtEdge = 1'b0;
    int curExp = 0;
    bit curOvf = 1'b0;
    int holdOut = 0;
    bit holdOvf = 1'b0;

    mac5_dot dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .A4        (A4),
        .A5        (A5),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .c5        (c5),
        .in_valid  (in_valid),
        .Output    (Output),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic int modelDot(input logic [4:0][7:0] a, input logic [4:0][7:0] c);
        int s = 0;
        for (int i = 0; i < 5; i++) begin
            s += int'(a[i]) * int'(c[i]);
        end
        return s;
    endfunction

    task automatic applyStimulus(input logic [4:0][7:0] a, input logic [4:0][7:0] c,
                                 input bit valid, input int expOut, input bit expOvf);
        @(posedge clk);
        #1;
        {A5, A4, A3, A2, A1} = a;
        {c5, c4, c3, c2, c1} = c;
        in_valid = valid;
        curExp = expOut;
        curOvf = expOvf;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            {A5, A4, A3, A2, A1} = 40'($urandom) ^ {8'($urandom), 32'd0};
            {c5, c4, c3, c2, c1} = 40'($urandom) ^ {8'($urandom), 32'd0};
        end
    endtask

    // Scoreboard push happens at the sampling edge; a reset edge discards everything in flight.
    always @(posedge clk) begin : sbPush
        exp_t e;
        cycle++;
        started = 1'b1;
        if (!rst_n) begin
            rstAtEdge = 1'b1;
            q.delete();
        end else begin
            rstAtEdge = 1'b0;
            if (in_valid) begin
                e.out = curExp;
                e.ovf = curOvf;
                e.cyc = cycle;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   expValid;
        if (started) begin
            if (rstAtEdge) begin
                checkOutput("reset_valid", 32'(out_valid), 0);
                checkOutput("reset_out", 32'(Output), 0);
                checkOutput("reset_ovf", 32'(overflow), 0);
                holdOut = 0;
                holdOvf = 1'b0;
            end else begin
                expValid = (q.size() > 0) && (cycle - q[0].cyc + 1 >= 3);
                checkOutput("out_valid", 32'(out_valid), 32'(expValid));
                if (out_valid && q.size() > 0) begin
                    e = q.pop_front();
                    checkOutput("result", 32'(Output), e.out);
                    checkOutput("overflow", 32'(overflow), 32'(e.ovf));
                    checkOutput("latency", cycle - e.cyc + 1, 3);
                    holdOut = e.out;
                    holdOvf = e.ovf;
                end else if (!out_valid) begin
                    checkOutput("hold_out", 32'(Output), holdOut);
                    checkOutput("hold_ovf", 32'(overflow), 32'(holdOvf));
                end
            end
        end
    end

    initial begin
        logic [4:0][7:0] ra;
        logic [4:0][7:0] rc;
        int              s;

        // Packed order is {A5,A4,A3,A2,A1}, so element 0 is tap 1.
        vecs[0] = '{a: {5{8'd1}}, c: {5{8'd1}}, expOut: 5, expOvf: 1'b0};
        vecs[1] = '{a: {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, c: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                    expOut: 550, expOvf: 1'b0};
        vecs[2] = '{a: {5{8'd255}}, c: {5{8'd255}}, expOut: 65535, expOvf: 1'b1};
        vecs[3] = '{a: {32'd0, 8'd255}, c: {32'd0, 8'd255}, expOut: 65025, expOvf: 1'b0};
        vecs[4] = '{a: '0, c: '0, expOut: 0, expOvf: 1'b0};
        vecs[5] = '{a: {24'd0, 8'd255, 8'd255}, c: {24'd0, 8'd2, 8'd255}, expOut: 65535, expOvf: 1'b0};
        vecs[6] = '{a: {16'd0, 8'd1, 8'd255, 8'd255}, c: {16'd0, 8'd1, 8'd2, 8'd255},
                    expOut: 65535, expOvf: 1'b1};
        vecs[7] = '{a: {8'd3, 8'd25, 8'd50, 8'd100, 8'd200}, c: {8'd17, 8'd13, 8'd11, 8'd7, 8'd3},
                    expOut: 2226, expOvf: 1'b0};

        {A5, A4, A3, A2, A1} = '0;
        {c5, c4, c3, c2, c1} = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] isolated vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].c, 1'b1, vecs[i].expOut, vecs[i].expOvf);
            idleCycles(4);
        end

        $display("[TB] back-to-back vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].c, 1'b1, vecs[i].expOut, vecs[i].expOvf);
        end
        idleCycles(4);

        $display("[TB] scaled A sequence");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus({5{8'(k)}}, {5{8'd1}}, 1'b1, 5 * k, 1'b0);
        end
        idleCycles(4);

        $display("[TB] reset with two sets in flight");
        applyStimulus(vecs[1].a, vecs[1].c, 1'b1, vecs[1].expOut, vecs[1].expOvf);
        applyStimulus(vecs[2].a, vecs[2].c, 1'b1, vecs[2].expOut, vecs[2].expOvf);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        idleCycles(3);
        applyStimulus(vecs[7].a, vecs[7].c, 1'b1, vecs[7].expOut, vecs[7].expOvf);
        idleCycles(4);

        $display("[TB] random operands with random gaps");
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 5; i++) begin
                ra[i] = (n % 3 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
                rc[i] = (n % 3 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
            end
            s = modelDot(ra, rc);
            applyStimulus(ra, rc, 1'($urandom_range(0, 1)), (s > 65535) ? 65535 : s, s > 65535);
        end
        idleCycles(5);

        checkOutput("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
